// File: rtl/cart_dispatcher.sv
// SCAN-policy dispatcher for a single cart serving eight stations.
// It latches station calls, picks the next stop and steps the cart towards it.
`timescale 1ns/1ps

module cart_dispatcher #(
    parameter int unsigned DWELL_TICKS = 4
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [7:0] CALL,
    input  logic [7:0] POS,
    input  logic       TICK,
    output logic       STEP_R,
    output logic       STEP_L,
    output logic       DOOR_OPEN,
    output logic       BUSY,
    output logic       FAULT,
    output logic [2:0] TARGET,
    output logic [7:0] PENDING,
    output logic [7:0] SERVED
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_MOVE,
        S_DWELL,
        S_FAULT
    } state_t;

    state_t     state, state_nx;
    logic       dir_r, dir_nx;
    logic [2:0] target_nx;
    logic [7:0] dwell_cnt, dwell_nx;
    logic [2:0] cur;
    logic       pos_ok;
    logic       up_found, dn_found;
    logic [2:0] up_idx, dn_idx;
    logic       enter_dwell;
    logic [7:0] set_mask, clr_mask;

    always_comb begin : pos_decode
        cur = '0;
        for (int i = 0; i < 8; i++) begin
            if (POS[i]) cur = cur | 3'(i);
        end
        pos_ok = (POS != '0) && ((POS & (POS - 8'd1)) == '0);
    end

    // Nearest pending station at or beyond the cart in each direction.
    always_comb begin : scan
        up_found = 1'b0;
        dn_found = 1'b0;
        up_idx   = '0;
        dn_idx   = '0;
        for (int i = 7; i >= 0; i--) begin
            if (PENDING[i] && (3'(i) >= cur)) begin
                up_found = 1'b1;
                up_idx   = 3'(i);
            end
        end
        for (int i = 0; i < 8; i++) begin
            if (PENDING[i] && (3'(i) <= cur)) begin
                dn_found = 1'b1;
                dn_idx   = 3'(i);
            end
        end
    end

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin : next_state
        state_nx    = state;
        dir_nx      = dir_r;
        target_nx   = TARGET;
        dwell_nx    = dwell_cnt;
        enter_dwell = 1'b0;
        STEP_R      = 1'b0;
        STEP_L      = 1'b0;
        if (!pos_ok) begin
            state_nx = S_FAULT;
        end else begin
            case (state)
                S_IDLE: if (PENDING != '0) state_nx = S_SELECT;
                S_SELECT: begin
                    if (dir_r && up_found) begin
                        target_nx = up_idx;
                    end else if (!dir_r && dn_found) begin
                        target_nx = dn_idx;
                    end else if (dir_r) begin
                        dir_nx    = 1'b0;
                        target_nx = dn_idx;
                    end else begin
                        dir_nx    = 1'b1;
                        target_nx = up_idx;
                    end
                    if (PENDING == '0) begin
                        state_nx = S_IDLE;
                        dir_nx   = dir_r;
                    end else if (target_nx == cur) begin
                        state_nx    = S_DWELL;
                        enter_dwell = 1'b1;
                    end else begin
                        state_nx = S_MOVE;
                    end
                end
                S_MOVE: begin
                    if (TARGET == cur) begin
                        state_nx    = S_DWELL;
                        enter_dwell = 1'b1;
                    end else if (TICK) begin
                        STEP_R = (TARGET > cur);
                        STEP_L = (TARGET < cur);
                    end
                end
                S_DWELL: begin
                    if (TICK) begin
                        if (dwell_cnt <= 8'd1) begin
                            dwell_nx = '0;
                            state_nx = S_IDLE;
                        end else begin
                            dwell_nx = dwell_cnt - 8'd1;
                        end
                    end
                end
                S_FAULT: state_nx = S_IDLE;
                default: state_nx = S_IDLE;
            endcase
        end
        if (enter_dwell) dwell_nx = 8'(DWELL_TICKS);
    end

    // A call for the station being served is absorbed; service clears only on DWELL entry.
    always_comb begin : request_masks
        set_mask = CALL;
        if (state == S_DWELL) set_mask[TARGET] = 1'b0;
        clr_mask = enter_dwell ? (8'd1 << target_nx) : 8'd0;
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state     <= S_IDLE;
            dir_r     <= 1'b1;
            TARGET    <= '0;
            dwell_cnt <= '0;
            PENDING   <= '0;
            SERVED    <= '0;
        end else begin
            state     <= state_nx;
            dir_r     <= dir_nx;
            TARGET    <= target_nx;
            dwell_cnt <= dwell_nx;
            PENDING   <= (PENDING | set_mask) & ~clr_mask;
            SERVED    <= clr_mask;
        end
    end

    assign DOOR_OPEN = (state == S_DWELL);
    assign BUSY      = (state == S_SELECT) || (state == S_MOVE) || (state == S_DWELL);
    assign FAULT     = (state == S_FAULT);

endmodule

// File: tb/tb_cart_dispatcher.sv
// Directed and randomized check of cart_dispatcher against a SCAN service-order model.
// A simple cart model moves POS one station per observed step pulse.
`timescale 1ns/1ps

module tb_cart_dispatcher;

    logic       CLK = 1'b0;
    logic       RESET;
    logic [7:0] CALL;
    logic [7:0] POS;
    logic       TICK;
    logic       STEP_R, STEP_L, DOOR_OPEN, BUSY, FAULT;
    logic [2:0] TARGET;
    logic [7:0] PENDING, SERVED;

    always #5 CLK = ~CLK;

    cart_dispatcher #(.DWELL_TICKS(4)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .CALL     (CALL),
        .POS      (POS),
        .TICK     (TICK),
        .STEP_R   (STEP_R),
        .STEP_L   (STEP_L),
        .DOOR_OPEN(DOOR_OPEN),
        .BUSY     (BUSY),
        .FAULT    (FAULT),
        .TARGET   (TARGET),
        .PENDING  (PENDING),
        .SERVED   (SERVED)
    );

    int n_assert = 0;
    int n_fail   = 0;

    bit         follow    = 1'b1;
    int         tick_mode = 0;
    int         cyc_cnt   = 0;
    bit         pend_r    = 1'b0;
    bit         pend_l    = 1'b0;
    int         n_r, n_l, door_ticks;
    logic [7:0] served_q[$];

    int         m_pos;
    bit         m_dir;
    logic [7:0] exp_q[$];
    int         exp_r, exp_l;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clr();
        n_r        = 0;
        n_l        = 0;
        door_ticks = 0;
        served_q.delete();
    endtask

    // One clock: the cart follows the previous cycle's step, then outputs are sampled mid-cycle.
    task automatic cyc();
        @(posedge CLK);
        #1;
        if (follow && pend_r) POS = POS << 1;
        else if (follow && pend_l) POS = POS >> 1;
        pend_r = 1'b0;
        pend_l = 1'b0;
        cyc_cnt++;
        case (tick_mode)
            0:       TICK = (cyc_cnt % 3 == 0);
            1:       TICK = ($urandom_range(0, 2) == 0);
            default: TICK = 1'b1;
        endcase
        @(negedge CLK);
        check("step_exclusive", 32'(STEP_R & STEP_L), 0);
        check("step_needs_tick", 32'((STEP_R | STEP_L) & ~TICK), 0);
        if (STEP_R) begin n_r++; pend_r = 1'b1; end
        if (STEP_L) begin n_l++; pend_l = 1'b1; end
        if (DOOR_OPEN && TICK) door_ticks++;
        if (SERVED != 8'd0) begin
            served_q.push_back(SERVED);
            check("served_at_pos", 32'(SERVED), 32'(POS));
        end
    endtask

    task automatic run_to_idle(input string tag);
        int k = 0;
        while (!(PENDING == 8'd0 && !BUSY) && k < 3000) begin
            cyc();
            k++;
        end
        check({tag, "_done"}, 32'(k < 3000), 1);
    endtask

    // Next stop by SCAN: search outward from pos in the requested direction.
    function automatic int pick(input logic [7:0] r, input int pos, input bit right);
        if (right) begin
            for (int i = pos; i <= 7; i++) if (r[i]) return i;
        end else begin
            for (int i = pos; i >= 0; i--) if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_serve(input logic [7:0] req);
        logic [7:0] r = req;
        int t;
        exp_q.delete();
        exp_r = 0;
        exp_l = 0;
        while (r != 8'd0) begin
            t = pick(r, m_pos, m_dir);
            if (t < 0) begin
                m_dir = !m_dir;
                t     = pick(r, m_pos, m_dir);
            end
            if (t > m_pos) exp_r += t - m_pos;
            else exp_l += m_pos - t;
            exp_q.push_back(8'(1 << t));
            r[t]  = 1'b0;
            m_pos = t;
        end
    endtask

    task automatic compare_model(input string tag);
        check({tag, "_nserved"}, 32'(served_q.size()), 32'(exp_q.size()));
        foreach (exp_q[i]) begin
            if (i < served_q.size()) check({tag, "_served"}, 32'(served_q[i]), 32'(exp_q[i]));
        end
        check({tag, "_steps_r"}, 32'(n_r), 32'(exp_r));
        check({tag, "_steps_l"}, 32'(n_l), 32'(exp_l));
        check({tag, "_final_pos"}, 32'(POS), 32'(1 << m_pos));
    endtask

    initial begin
        int k;
        int n_before;
        logic [7:0] req;
        int p;

        RESET = 1'b1;
        CALL  = 8'd0;
        POS   = 8'h01;
        TICK  = 1'b0;
        m_pos = 0;
        m_dir = 1'b1;
        repeat (2) @(negedge CLK);
        check("rst_step_r", 32'(STEP_R), 0);
        check("rst_step_l", 32'(STEP_L), 0);
        check("rst_door", 32'(DOOR_OPEN), 0);
        check("rst_busy", 32'(BUSY), 0);
        check("rst_fault", 32'(FAULT), 0);
        check("rst_target", 32'(TARGET), 0);
        check("rst_pending", 32'(PENDING), 0);
        check("rst_served", 32'(SERVED), 0);
        RESET = 1'b0;
        cyc();
        cyc();

        // Single call three stations to the right.
        clr();
        CALL = 8'h08;
        cyc();
        CALL = 8'h00;
        check("t1_pending", 32'(PENDING), 32'h08);
        model_serve(8'h08);
        run_to_idle("t1");
        compare_model("t1");
        check("t1_steps_r_const", 32'(n_r), 3);
        check("t1_door_ticks", 32'(door_ticks), 4);
        check("t1_idle_busy", 32'(BUSY), 0);

        // Two calls on opposite sides: continue right first, then reverse.
        POS   = 8'h10;
        m_pos = 4;
        clr();
        CALL = 8'h41;
        cyc();
        CALL = 8'h00;
        model_serve(8'h41);
        run_to_idle("t2");
        compare_model("t2");
        check("t2_first", 32'(served_q.size() > 0 ? served_q[0] : 8'h00), 32'h40);
        check("t2_steps_r_const", 32'(n_r), 2);
        check("t2_steps_l_const", 32'(n_l), 6);

        // Call at the current station while idle, held through DWELL.
        POS   = 8'h04;
        m_pos = 2;
        clr();
        CALL = 8'h04;
        k = 0;
        while (!DOOR_OPEN && k < 50) begin cyc(); k++; end
        check("t3_reach_dwell", 32'(DOOR_OPEN), 1);
        check("t3_served", 32'(SERVED), 32'h04);
        check("t3_pending_entry", 32'(PENDING), 0);
        cyc();
        check("t3_pending_hold1", 32'(PENDING), 0);
        cyc();
        check("t3_pending_hold2", 32'(PENDING), 0);
        CALL = 8'h00;
        run_to_idle("t3");
        check("t3_no_steps", 32'(n_r + n_l), 0);
        check("t3_nserved", 32'(served_q.size()), 1);

        // Invalid position during MOVE, then recovery.
        POS   = 8'h02;
        m_pos = 1;
        clr();
        CALL = 8'h20;
        cyc();
        CALL = 8'h00;
        model_serve(8'h20);
        k = 0;
        while (n_r == 0 && k < 100) begin cyc(); k++; end
        check("t4_first_step", 32'(n_r), 1);
        cyc();
        follow    = 1'b0;
        tick_mode = 2;
        POS       = 8'h00;
        TICK      = 1'b1;
        #1;
        check("t4_fault_no_step_r", 32'(STEP_R), 0);
        check("t4_fault_no_step_l", 32'(STEP_L), 0);
        cyc();
        check("t4_fault", 32'(FAULT), 1);
        check("t4_fault_busy", 32'(BUSY), 0);
        check("t4_fault_pending", 32'(PENDING), 32'h20);
        n_before = n_r + n_l;
        repeat (3) cyc();
        check("t4_fault_steps", 32'(n_r + n_l), 32'(n_before));
        POS       = 8'h02;
        follow    = 1'b1;
        tick_mode = 0;
        cyc();
        check("t4_recover_fault", 32'(FAULT), 0);
        check("t4_recover_pending", 32'(PENDING), 32'h20);
        clr();
        exp_r = 4;
        exp_l = 0;
        run_to_idle("t4");
        compare_model("t4");

        // Reset in the middle of DWELL with other calls outstanding.
        POS   = 8'h10;
        m_pos = 4;
        clr();
        CALL = 8'h10;
        cyc();
        CALL = 8'h00;
        k = 0;
        while (!DOOR_OPEN && k < 50) begin cyc(); k++; end
        CALL = 8'h81;
        cyc();
        CALL = 8'h00;
        check("t5_dwell", 32'(DOOR_OPEN), 1);
        check("t5_pending", 32'(PENDING), 32'h81);
        RESET = 1'b1;
        #1;
        check("t5_rst_pending", 32'(PENDING), 0);
        check("t5_rst_door", 32'(DOOR_OPEN), 0);
        check("t5_rst_busy", 32'(BUSY), 0);
        check("t5_rst_served", 32'(SERVED), 0);
        check("t5_rst_target", 32'(TARGET), 0);
        @(negedge CLK);
        RESET = 1'b0;
        m_dir = 1'b1;
        clr();
        tick_mode = 2;
        repeat (20) cyc();
        check("t5_no_steps", 32'(n_r + n_l), 0);
        check("t5_idle", 32'(BUSY), 0);
        check("t5_pending_after", 32'(PENDING), 0);

        // Random call bursts from random positions against the SCAN model.
        tick_mode = 1;
        for (int it = 0; it < 10; it++) begin
            p     = $urandom_range(0, 7);
            req   = 8'($urandom_range(1, 255));
            POS   = 8'(1 << p);
            m_pos = p;
            clr();
            CALL = req;
            cyc();
            CALL = 8'h00;
            model_serve(req);
            run_to_idle("rnd");
            compare_model("rnd");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/cart_dispatcher.md
CART_DISPATCHER -- requirements
Module: cart_dispatcher

Interface
REQ-001 The block SHALL have parameter DWELL_TICKS, default 4, giving the number of TICK pulses the cart dwells at a served station (legal range 1..255).
REQ-002 The block SHALL have port CLK, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port RESET, input, 1 bit: asynchronous, active-high reset.
REQ-004 The block SHALL have port CALL, input, 8 bits: level station-call requests; bit i requests station i.
REQ-005 The block SHALL have port POS, input, 8 bits: one-hot cart position from the cart FSM; bit 0 is the leftmost station.
REQ-006 The block SHALL have port TICK, input, 1 bit: a one-CLK-cycle step-rate enable.
REQ-007 The block SHALL have port STEP_R, output, 1 bit: one-cycle pulse commanding one step right (index +1).
REQ-008 The block SHALL have port STEP_L, output, 1 bit: one-cycle pulse commanding one step left (index -1).
REQ-009 The block SHALL have port DOOR_OPEN, output, 1 bit: high while in DWELL.
REQ-010 The block SHALL have port BUSY, output, 1 bit: high in SELECT, MOVE or DWELL.
REQ-011 The block SHALL have port FAULT, output, 1 bit: high in FAULT.
REQ-012 The block SHALL have port TARGET, output, 3 bits: index of the station being served.
REQ-013 The block SHALL have port PENDING, output, 8 bits: the registered outstanding-request vector.
REQ-014 The block SHALL have port SERVED, output, 8 bits: one-cycle one-hot pulse marking the station just served.

Function
REQ-015 The block SHALL set PENDING[i] one cycle after any cycle with CALL[i]=1, and clear it only on service.
REQ-016 The block SHALL implement the states IDLE, SELECT, MOVE, DWELL and FAULT.
REQ-017 In IDLE, when PENDING is non-zero, the block SHALL go to SELECT on the next cycle.
REQ-018 In SELECT, in one cycle, the block SHALL use a SCAN policy: with direction DIR_R=1, TARGET is the lowest pending index >= current; with DIR_R=0, TARGET is the highest pending index <= current.
REQ-019 If no pending request exists in the current direction, the block SHALL invert DIR_R and choose in the opposite direction in the same SELECT cycle; it SHALL then go to MOVE, or to DWELL if TARGET equals the current index.
REQ-020 In MOVE, on each TICK cycle, the block SHALL pulse STEP_R if TARGET > current or STEP_L if TARGET < current, and SHALL never assert STEP_R and STEP_L together.
REQ-021 In MOVE, when the current index equals TARGET, the block SHALL go to DWELL without stepping, and SHALL NOT re-target in response to new calls during MOVE.
REQ-022 On DWELL entry the block SHALL pulse SERVED[TARGET] for one cycle, clear PENDING[TARGET], and load the dwell counter with DWELL_TICKS.
REQ-023 In DWELL, the block SHALL decrement the counter on each TICK, and on the TICK that reaches 0 go to IDLE; CALL[TARGET] asserted during DWELL SHALL be absorbed and SHALL NOT set PENDING.
REQ-024 In any state, if POS is not one-hot (zero or multi-bit), the block SHALL go to FAULT on the next cycle, suppress STEP_R and STEP_L, and retain PENDING.
REQ-025 In FAULT, the block SHALL return to IDLE on the first cycle POS is one-hot again; an interrupted DWELL SHALL NOT re-pulse SERVED.
REQ-026 When CALL[i] sets and service clears PENDING[i] in the same cycle, clear SHALL win only for i=TARGET at DWELL entry; otherwise set SHALL win.
REQ-027 The current index SHALL be the binary encoding of POS, recomputed combinationally each cycle.

Reset
REQ-028 On RESET=1, asynchronously, the block SHALL enter IDLE and SHALL set PENDING=0, SERVED=0, TARGET=0, STEP_R=STEP_L=0, DOOR_OPEN=BUSY=FAULT=0, DIR_R=1 and dwell counter=0.
REQ-029 A reset asserted mid-MOVE or mid-DWELL SHALL discard all requests, and no step pulse SHALL follow reset release until a new CALL.

Verification
REQ-030 POS=0x01, pulse CALL=0x08 -> PENDING=0x08, then three STEP_R pulses on successive TICKs while POS advances, then SERVED=0x08, DOOR_OPEN for 4 TICKs, then IDLE.
REQ-031 POS=0x10, DIR_R=1, CALL=0x41 -> station 6 served first (2 STEP_R), then DIR_R flips and station 0 is served (6 STEP_L).
REQ-032 In IDLE at POS=0x04, CALL=0x04 -> DWELL with no step, SERVED=0x04; holding CALL=0x04 during DWELL leaves PENDING=0x00.
REQ-033 During MOVE, force POS=0x00 -> FAULT=1 and no STEP pulses; restore POS=0x02 -> IDLE, PENDING unchanged, service resumes.
REQ-034 Assert RESET mid-DWELL with PENDING=0x81 -> all outputs 0, PENDING=0x00, and no STEP pulses after release.
